// File: rtl/trng_ctrl_pkg.sv
// Shared types and register map for the ring-oscillator TRNG controller.
package trng_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    COLLECT = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_DATA   = 4'd1;
  localparam logic [3:0] ADDR_STATUS = 4'd2;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  localparam int ST_FAIL     = 7;
  localparam int ST_FULL     = 6;
  localparam int ST_AVAIL    = 5;
  localparam int ST_STATE_LO = 3;
  localparam int ST_LEVEL_LO = 0;

  // STATUS only has room for a 3-bit level, so deeper FIFOs report 7.
  function automatic logic [2:0] sat_level(input logic [31:0] lvl);
    return (lvl > 32'd7) ? 3'd7 : lvl[2:0];
  endfunction

endpackage

// File: rtl/trng_ctrl_fifo.sv
// Byte FIFO: push/pop take effect at the clock edge, head is combinational (0x00 when empty).
// A push into a full FIFO is accepted only if a pop frees the slot in the same cycle.
module trng_ctrl_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/trng_ctrl.sv
// TRNG sequencer: oscillator gating, warm-up discard, LSB-first byte packing, repetition-count test.
// First byte lands WARMUP_CYCLES+8 edges after enable; packing stalls while the FIFO is full.
module trng_ctrl #(
  parameter int FIFO_DEPTH    = 4,
  parameter int WARMUP_CYCLES = 64,
  parameter int RCT_LIMIT     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_bit,
  output logic       ro_en,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic       data_read,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       health_fail
);
  import trng_ctrl_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(WARMUP_CYCLES + 1);

  state_t state, state_n;
  logic          en_q;
  logic          en_n;
  logic [WW-1:0] wu_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    byte_n;
  logic [7:0]    run_cnt;
  logic          prev_bit;

  logic          ctrl_wr;
  logic          clr;
  logic          pop;
  logic          push;
  logic          flush;
  logic          shift_en;
  logic          run_hit;
  logic          fault_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [7:0]    fifo_head;
  logic          unused_bits;

  assign unused_bits = ^data_in[7:2];

  // Enable and clear act on the same edge as the write, so decode them combinationally.
  assign ctrl_wr     = data_write && (address == ADDR_CTRL);
  assign clr         = ctrl_wr && data_in[CTRL_CLR];
  assign en_n        = ctrl_wr ? data_in[CTRL_EN] : en_q;
  assign pop         = data_read && (address == ADDR_DATA);
  assign run_hit     = (run_cnt == 8'(RCT_LIMIT));
  assign fault_entry = (state == COLLECT) && run_hit;
  assign shift_en    = (state == COLLECT) && en_n && !clr && !run_hit && !fifo_full;
  assign push        = shift_en && (bit_cnt == 3'd7);
  assign flush       = clr || fault_entry;

  always_comb begin
    byte_n          = shreg;
    byte_n[bit_cnt] = raw_bit;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (en_n) state_n = WARMUP;
      end
      WARMUP: begin
        if (!en_n) state_n = IDLE;
        else if (wu_cnt == WW'(WARMUP_CYCLES - 1)) state_n = COLLECT;
      end
      COLLECT: begin
        if (run_hit) state_n = FAULT;
        else if (!en_n) state_n = IDLE;
      end
      FAULT: begin
        if (clr) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      en_q     <= 1'b0;
      wu_cnt   <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      run_cnt  <= '0;
      prev_bit <= 1'b0;
    end else begin
      state    <= state_n;
      en_q     <= en_n;
      prev_bit <= raw_bit;
      wu_cnt   <= (state == WARMUP) ? wu_cnt + WW'(1) : '0;

      // Leaving COLLECT or clearing drops any partial byte.
      if (state != COLLECT || clr) bit_cnt <= '0;
      else if (shift_en)           bit_cnt <= bit_cnt + 3'd1;

      if (shift_en) shreg <= byte_n;

      // A zero run count marks the first sample, which always starts a new run.
      if (state != COLLECT) run_cnt <= '0;
      else if (!run_hit)
        run_cnt <= (run_cnt != 8'd0 && raw_bit == prev_bit) ? run_cnt + 8'd1 : 8'd1;
    end
  end

  trng_ctrl_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (byte_n),
    .pop       (pop),
    .flush     (flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign ro_en       = (state == WARMUP) || (state == COLLECT);
  assign health_fail = (state == FAULT);
  assign data_ready  = !fifo_empty;

  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_CTRL: data_out[CTRL_EN] = en_q;
      ADDR_DATA: data_out = fifo_head;
      ADDR_STATUS: begin
        data_out[ST_FAIL]            = health_fail;
        data_out[ST_FULL]            = fifo_full;
        data_out[ST_AVAIL]           = !fifo_empty;
        data_out[ST_STATE_LO +: 2]   = state;
        data_out[ST_LEVEL_LO +: 3]   = sat_level(32'(fifo_level));
      end
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_trng_ctrl.sv
// Scenario bench for trng_ctrl; expected bytes are queued as bits are driven and checked on pop.
module tb_trng_ctrl;

  localparam int W     = 64;
  localparam int DEPTH = 4;
  localparam int LIMIT = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       raw_bit = 1'b0;
  logic       ro_en;
  logic [3:0] address = 4'd0;
  logic       data_write = 1'b0;
  logic       data_read = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_ready;
  logic       health_fail;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];

  trng_ctrl #(
    .FIFO_DEPTH    (DEPTH),
    .WARMUP_CYCLES (W),
    .RCT_LIMIT     (LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .raw_bit     (raw_bit),
    .ro_en       (ro_en),
    .address     (address),
    .data_write  (data_write),
    .data_read   (data_read),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_ready  (data_ready),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    address = a; data_in = d; data_write = 1'b1;
    tick();
    data_write = 1'b0; data_in = 8'h00;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [7:0] v);
    address = a;
    #1;
    v = data_out;
  endtask

  task automatic pop_data(output logic [7:0] v);
    address = 4'd1;
    #1;
    v = data_out;
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    for (int a = 0; a < 4; a++) begin
      read_reg(4'(a), v);
      total_cnt++; if (v !== 8'h00) $display("FAIL reset_read_%0d: got %h want 00", a, v); else pass_cnt++;
    end
    total_cnt++; if (ro_en !== 1'b0) $display("FAIL reset_ro_en: got %b want 0", ro_en); else pass_cnt++;
    total_cnt++; if (data_ready !== 1'b0) $display("FAIL reset_data_ready: got %b want 0", data_ready); else pass_cnt++;
    total_cnt++; if (health_fail !== 1'b0) $display("FAIL reset_health_fail: got %b want 0", health_fail); else pass_cnt++;
  endtask

  task automatic test_first_byte;
    logic seq [8];
    logic [7:0] exp_b;
    logic [7:0] v;
    int cyc;
    seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_b = 8'h00;
    for (int i = 0; i < 8; i++) exp_b[i] = seq[i];
    cpu_write(4'd0, 8'h01);
    total_cnt++; if (ro_en !== 1'b1) $display("FAIL enable_ro_en: got %b want 1", ro_en); else pass_cnt++;
    cyc = 0;
    while (!data_ready && cyc < 200) begin
      if (cyc >= W && cyc < W + 8) raw_bit = seq[cyc - W];
      else raw_bit = cyc[0];
      // Pop on an empty FIFO in the same cycle the first byte is pushed.
      if (cyc == W + 7) begin
        address = 4'd1; data_read = 1'b1;
        exp_q.push_back(exp_b);
      end
      tick();
      data_read = 1'b0;
      cyc++;
    end
    total_cnt++; if (cyc !== W + 8) $display("FAIL first_byte_latency: got %0d cycles want %0d", cyc, W + 8); else pass_cnt++;
    pop_data(v);
    total_cnt++; if (exp_q.size() == 0 || v !== exp_q[0]) $display("FAIL first_byte_data: got %h want 4d", v); else pass_cnt++;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    total_cnt++; if (data_ready !== 1'b0) $display("FAIL first_byte_drain: got %b want 0", data_ready); else pass_cnt++;
    read_reg(4'd1, v);
    total_cnt++; if (v !== 8'h00) $display("FAIL empty_data_read: got %h want 00", v); else pass_cnt++;
    cpu_write(4'd0, 8'h00);
    total_cnt++; if (ro_en !== 1'b0) $display("FAIL disable_ro_en: got %b want 0", ro_en); else pass_cnt++;
  endtask

  task automatic test_fifo_full;
    logic [7:0] v;
    logic [7:0] acc;
    logic [7:0] b_a5;
    logic [7:0] b_3c;
    int n;
    b_a5 = 8'hA5;
    b_3c = 8'h3C;
    acc = 8'h00;
    cpu_write(4'd0, 8'h01);
    read_reg(4'd0, v);
    total_cnt++; if (v !== 8'h01) $display("FAIL ctrl_readback: got %h want 01", v); else pass_cnt++;
    raw_bit = 1'b0;
    repeat (W) tick();
    read_reg(4'd2, v);
    total_cnt++; if (v !== 8'h10) $display("FAIL status_collect: got %h want 10", v); else pass_cnt++;
    for (int i = 0; i < 48; i++) begin
      raw_bit = ~i[0];
      if (i < 32) begin
        acc[i % 8] = raw_bit;
        if (i % 8 == 7) exp_q.push_back(acc);
      end
      tick();
    end
    read_reg(4'd2, v);
    total_cnt++; if (v !== 8'h74) $display("FAIL status_full: got %h want 74", v); else pass_cnt++;
    total_cnt++; if (data_ready !== 1'b1) $display("FAIL full_data_ready: got %b want 1", data_ready); else pass_cnt++;
    pop_data(v);
    total_cnt++; if (v !== exp_q.pop_front()) $display("FAIL full_pop_0: got %h want 55", v); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      raw_bit = b_a5[i];
      if (i == 7) exp_q.push_back(b_a5);
      tick();
      if (i == 6) begin
        read_reg(4'd2, v);
        total_cnt++; if (v !== 8'h33) $display("FAIL refill_before_8: got %h want 33", v); else pass_cnt++;
      end
    end
    read_reg(4'd2, v);
    total_cnt++; if (v !== 8'h74) $display("FAIL refill_after_8: got %h want 74", v); else pass_cnt++;
    pop_data(v);
    total_cnt++; if (v !== exp_q.pop_front()) $display("FAIL full_pop_1: got %h want 55", v); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      raw_bit = b_3c[i];
      if (i == 7) begin
        address = 4'd1;
        #1;
        v = data_out;
        total_cnt++; if (v !== exp_q.pop_front()) $display("FAIL pushpop_head: got %h want 55", v); else pass_cnt++;
        exp_q.push_back(b_3c);
        data_read = 1'b1;
      end
      tick();
      data_read = 1'b0;
    end
    read_reg(4'd2, v);
    total_cnt++; if (v !== 8'h33) $display("FAIL pushpop_level: got %h want 33", v); else pass_cnt++;
    cpu_write(4'd0, 8'h00);
    total_cnt++; if (ro_en !== 1'b0) $display("FAIL full_disable: got %b want 0", ro_en); else pass_cnt++;
    n = 0;
    while (data_ready && n < 8) begin
      pop_data(v);
      total_cnt++;
      if (exp_q.size() == 0) $display("FAIL drain_extra: got %h want nothing", v);
      else if (v !== exp_q[0]) $display("FAIL drain_%0d: got %h want %h", n, v, exp_q[0]);
      else pass_cnt++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      n++;
    end
    total_cnt++; if (n !== 3) $display("FAIL drain_count: got %0d want 3", n); else pass_cnt++;
  endtask

  task automatic test_health;
    logic [7:0] v;
    int cyc;
    cpu_write(4'd0, 8'h01);
    raw_bit = 1'b1;
    repeat (W) tick();
    repeat (LIMIT - 1) tick();
    raw_bit = 1'b0;
    tick();
    total_cnt++; if (health_fail !== 1'b0) $display("FAIL rct_below_limit: got %b want 0", health_fail); else pass_cnt++;
    read_reg(4'd2, v);
    total_cnt++; if (v[4:3] !== 2'd2) $display("FAIL rct_still_collect: got %0d want 2", v[4:3]); else pass_cnt++;
    raw_bit = 1'b1;
    cyc = 0;
    while (!health_fail && cyc < 100) begin
      tick();
      cyc++;
    end
    total_cnt++; if (cyc !== LIMIT + 1) $display("FAIL rct_fault_time: got %0d want %0d", cyc, LIMIT + 1); else pass_cnt++;
    total_cnt++; if (ro_en !== 1'b0) $display("FAIL fault_ro_en: got %b want 0", ro_en); else pass_cnt++;
    total_cnt++; if (data_ready !== 1'b0) $display("FAIL fault_flush: got %b want 0", data_ready); else pass_cnt++;
    read_reg(4'd2, v);
    total_cnt++; if (v !== 8'h98) $display("FAIL fault_status: got %h want 98", v); else pass_cnt++;
    exp_q.delete();
    cpu_write(4'd0, 8'h01);
    total_cnt++; if (health_fail !== 1'b1) $display("FAIL fault_sticky: got %b want 1", health_fail); else pass_cnt++;
    cpu_write(4'd0, 8'h03);
    total_cnt++; if (health_fail !== 1'b0) $display("FAIL clear_health: got %b want 0", health_fail); else pass_cnt++;
    read_reg(4'd2, v);
    total_cnt++; if (v !== 8'h00) $display("FAIL clear_idle_status: got %h want 00", v); else pass_cnt++;
    tick();
    total_cnt++; if (ro_en !== 1'b1) $display("FAIL clear_rewarm_ro_en: got %b want 1", ro_en); else pass_cnt++;
    read_reg(4'd2, v);
    total_cnt++; if (v !== 8'h08) $display("FAIL clear_warmup_status: got %h want 08", v); else pass_cnt++;
    cpu_write(4'd0, 8'h00);
  endtask

  task automatic test_clear;
    logic [7:0] v;
    cpu_write(4'd0, 8'h01);
    repeat (W) tick();
    for (int i = 0; i < 24; i++) begin
      raw_bit = ~i[0];
      tick();
    end
    total_cnt++; if (data_ready !== 1'b1) $display("FAIL clear_pre_ready: got %b want 1", data_ready); else pass_cnt++;
    cpu_write(4'd0, 8'h03);
    total_cnt++; if (data_ready !== 1'b0) $display("FAIL clear_flush: got %b want 0", data_ready); else pass_cnt++;
    read_reg(4'd2, v);
    total_cnt++; if (v !== 8'h10) $display("FAIL clear_keeps_state: got %h want 10", v); else pass_cnt++;
    for (int i = 0; i < 24; i++) begin
      raw_bit = ~i[0];
      tick();
    end
    read_reg(4'd2, v);
    total_cnt++; if (v !== 8'h33) $display("FAIL clear_refill: got %h want 33", v); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    address = 4'd2;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (ro_en !== 1'b0) $display("FAIL arst_ro_en: got %b want 0", ro_en); else pass_cnt++;
    total_cnt++; if (data_ready !== 1'b0) $display("FAIL arst_data_ready: got %b want 0", data_ready); else pass_cnt++;
    total_cnt++; if (health_fail !== 1'b0) $display("FAIL arst_health_fail: got %b want 0", health_fail); else pass_cnt++;
    total_cnt++; if (data_out !== 8'h00) $display("FAIL arst_status: got %h want 00", data_out); else pass_cnt++;
    address = 4'd1;
    #1;
    total_cnt++; if (data_out !== 8'h00) $display("FAIL arst_data: got %h want 00", data_out); else pass_cnt++;
    address = 4'd0;
    #1;
    total_cnt++; if (data_out !== 8'h00) $display("FAIL arst_ctrl: got %h want 00", data_out); else pass_cnt++;
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    total_cnt++; if (ro_en !== 1'b0) $display("FAIL arst_stays_idle: got %b want 0", ro_en); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_byte();
    test_fifo_full();
    test_health();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
